// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
// Data-memory bus between the MEM/WB stage (master) and the data memory
// (slave). The request channel is valid/ready; the response channel is a
// one-cycle valid pulse with no back-pressure.
//
// Signals:
//   mem_req_valid  master->slave  request valid
//   mem_req_ready  slave->master  request accepted when valid & ready
//   mem_req_we     master->slave  1 = store, 0 = load
//   mem_addr       master->slave  word-aligned byte address
//   mem_wdata      master->slave  store data
//   mem_rsp_valid  slave->master  load data valid (single-cycle pulse)
//   mem_rdata      slave->master  load data
// ---------------------------------------------------------------------------
interface mem_wb_stage_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req_valid,
      output mem_req_we,
      output mem_addr,
      output mem_wdata,
      input  mem_req_ready,
      input  mem_rsp_valid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_req_ready,
      output mem_rsp_valid,
      output mem_rdata
   );
endinterface

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Consumer end of the EX/MEM pipeline register. Performs the data-memory
// access for loads and stores over mem_wb_stage_if, stalls the upstream
// pipeline while an access is outstanding, and registers the MEM/WB outputs.
// Bubbles are inserted into W so each instruction writes the register file
// at most once.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in REQ+WAIT before aborting (2..255)
//   ERR_DATA        ReadDataW value for an aborted or misaligned load
//
// Ports:
//   CLK, rst                  clock, synchronous active-high reset
//   RegWriteM .. WriteRegM    M-stage control/data (held while StallM=1)
//   StallM                    freeze EX/MEM and earlier stages
//   mem                       data-memory bus (master side)
//   RegWriteW .. WriteRegW    registered W-stage outputs
//   MemErr                    one-cycle pulse on misaligned/timed-out access
// ---------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  RegWriteM,
   input  logic                  MemToRegM,
   input  logic                  MemWriteM,
   input  logic [31:0]           ALUOutM,
   input  logic [31:0]           WritedataM,
   input  logic [4:0]            WriteRegM,
   output logic                  StallM,
   mem_wb_stage_if.master        mem,
   output logic                  RegWriteW,
   output logic                  MemToRegW,
   output logic [31:0]           ALUOutW,
   output logic [31:0]           ReadDataW,
   output logic [4:0]            WriteRegW,
   output logic                  MemErr
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic        regwrite_q;
   logic        memtoreg_q;
   logic [31:0] aluout_q;
   logic [31:0] readdata_q;
   logic [4:0]  writereg_q;
   logic        memerr_q;

   logic        memop_s;
   logic        is_load_s;
   logic        misalign_s;
   logic        req_fire_s;
   logic        timeout_s;

   // Decode of the current M-stage op and of the bus handshake.
   assign memop_s    = MemToRegM | MemWriteM;
   // Both flags set is treated as a store, so only a pure MemToRegM is a load.
   assign is_load_s  = MemToRegM & ~MemWriteM;
   assign misalign_s = (ALUOutM[1:0] != 2'b00);
   assign req_fire_s = (state_q == S_REQ) & mem.mem_req_ready;
   // Counter is never cleared inside REQ/WAIT, so >= also covers a load that
   // was accepted on the last allowed REQ cycle.
   assign timeout_s  = (cnt_q >= TO_LAST);

   // Stall decode: aligned access starting in IDLE, or any cycle in REQ/WAIT.
   always_comb begin
      StallM = 1'b0;
      case (state_q)
         S_IDLE:  StallM = memop_s & ~misalign_s;
         S_REQ:   StallM = 1'b1;
         S_WAIT:  StallM = 1'b1;
         S_DONE:  StallM = 1'b0;
         default: StallM = 1'b0;
      endcase
   end

   // Bus outputs come from registered state/latches only, so they are glitch-free.
   assign mem.mem_req_valid = (state_q == S_REQ);
   assign mem.mem_req_we    = we_q;
   assign mem.mem_addr      = addr_q;
   assign mem.mem_wdata     = wdata_q;

   assign RegWriteW = regwrite_q;
   assign MemToRegW = memtoreg_q;
   assign ALUOutW   = aluout_q;
   assign ReadDataW = readdata_q;
   assign WriteRegW = writereg_q;
   assign MemErr    = memerr_q;

   // Access FSM together with the MEM/WB pipeline registers.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         we_q       <= 1'b0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         aluout_q   <= 32'd0;
         readdata_q <= 32'd0;
         writereg_q <= 5'd0;
         memerr_q   <= 1'b0;
      end else begin
         memerr_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (memop_s && misalign_s) begin
                  // Misaligned: no bus traffic, retire the op with the write suppressed.
                  regwrite_q <= 1'b0;
                  memtoreg_q <= MemToRegM;
                  aluout_q   <= ALUOutM;
                  writereg_q <= WriteRegM;
                  memerr_q   <= 1'b1;
                  if (is_load_s) begin
                     readdata_q <= ERR_DATA;
                  end else begin
                     readdata_q <= readdata_q;
                  end
               end else if (memop_s) begin
                  addr_q     <= {ALUOutM[31:2], 2'b00};
                  wdata_q    <= WritedataM;
                  we_q       <= MemWriteM;
                  cnt_q      <= 8'd0;
                  regwrite_q <= 1'b0;
                  memtoreg_q <= 1'b0;
                  state_q    <= S_REQ;
               end else begin
                  regwrite_q <= RegWriteM;
                  memtoreg_q <= MemToRegM;
                  aluout_q   <= ALUOutM;
                  writereg_q <= WriteRegM;
               end
            end
            S_REQ: begin
               cnt_q <= cnt_q + 8'd1;
               // Completion is checked first so it wins over a coincident timeout.
               if (req_fire_s) begin
                  if (we_q) begin
                     regwrite_q <= RegWriteM;
                     memtoreg_q <= MemToRegM;
                     aluout_q   <= ALUOutM;
                     writereg_q <= WriteRegM;
                     state_q    <= S_DONE;
                  end else begin
                     state_q    <= S_WAIT;
                  end
               end else if (timeout_s) begin
                  regwrite_q <= 1'b0;
                  memtoreg_q <= MemToRegM;
                  aluout_q   <= ALUOutM;
                  writereg_q <= WriteRegM;
                  memerr_q   <= 1'b1;
                  state_q    <= S_DONE;
                  if (!we_q) begin
                     readdata_q <= ERR_DATA;
                  end else begin
                     readdata_q <= readdata_q;
                  end
               end else begin
                  state_q <= S_REQ;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + 8'd1;
               if (mem.mem_rsp_valid) begin
                  readdata_q <= mem.mem_rdata;
                  regwrite_q <= RegWriteM;
                  memtoreg_q <= MemToRegM;
                  aluout_q   <= ALUOutM;
                  writereg_q <= WriteRegM;
                  state_q    <= S_DONE;
               end else if (timeout_s) begin
                  readdata_q <= ERR_DATA;
                  regwrite_q <= 1'b0;
                  memtoreg_q <= MemToRegM;
                  aluout_q   <= ALUOutM;
                  writereg_q <= WriteRegM;
                  memerr_q   <= 1'b1;
                  state_q    <= S_DONE;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_DONE: begin
               // The op retired on entry; a bubble here prevents a second write.
               regwrite_q <= 1'b0;
               memtoreg_q <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
// Directed bench for mem_wb_stage. Inputs change and outputs are sampled on
// the falling edge; combinational StallM is sampled #1 after an input change.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

   logic        CLK = 1'b0;
   logic        rst;
   logic        RegWriteM, MemToRegM, MemWriteM;
   logic [31:0] ALUOutM, WritedataM;
   logic [4:0]  WriteRegM;
   logic        StallM;
   logic        RegWriteW, MemToRegW;
   logic [31:0] ALUOutW, ReadDataW;
   logic [4:0]  WriteRegW;
   logic        MemErr;

   int n_checks = 0;
   int n_fail   = 0;

   mem_wb_stage_if mem_bus ();

   mem_wb_stage #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .CLK        (CLK),
      .rst        (rst),
      .RegWriteM  (RegWriteM),
      .MemToRegM  (MemToRegM),
      .MemWriteM  (MemWriteM),
      .ALUOutM    (ALUOutM),
      .WritedataM (WritedataM),
      .WriteRegM  (WriteRegM),
      .StallM     (StallM),
      .mem        (mem_bus),
      .RegWriteW  (RegWriteW),
      .MemToRegW  (MemToRegW),
      .ALUOutW    (ALUOutW),
      .ReadDataW  (ReadDataW),
      .WriteRegW  (WriteRegW),
      .MemErr     (MemErr)
   );

   // Free-running clock, 10 time-unit period.
   always #5 CLK = ~CLK;

   task automatic set_m(input logic rw, input logic m2r, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
      RegWriteM = rw; MemToRegM = m2r; MemWriteM = mw;
      ALUOutM = alu; WritedataM = wd; WriteRegM = wr;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rdata = 32'd0;
      repeat (2) @(negedge CLK);
      rst = 1'b0;
      #1;
      n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite: got %h exp 0", RegWriteW); end
      n_checks++; if (MemToRegW !== 1'b0) begin n_fail++; $display("FAIL rst_memtoreg: got %h exp 0", MemToRegW); end
      n_checks++; if (ALUOutW !== 32'd0) begin n_fail++; $display("FAIL rst_aluout: got %h exp 0", ALUOutW); end
      n_checks++; if (ReadDataW !== 32'd0) begin n_fail++; $display("FAIL rst_readdata: got %h exp 0", ReadDataW); end
      n_checks++; if (WriteRegW !== 5'd0) begin n_fail++; $display("FAIL rst_writereg: got %h exp 0", WriteRegW); end
      n_checks++; if (MemErr !== 1'b0) begin n_fail++; $display("FAIL rst_memerr: got %h exp 0", MemErr); end
      n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %h exp 0", mem_bus.mem_req_valid); end
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %h exp 0", StallM); end
      n_checks++; if (mem_bus.mem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", mem_bus.mem_addr); end
   endtask

   task automatic test_alu();
      @(negedge CLK);
      set_m(1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 5'd5);
      #1;
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %h exp 0", StallM); end
      @(negedge CLK);
      n_checks++; if (RegWriteW !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite: got %h exp 1", RegWriteW); end
      n_checks++; if (ALUOutW !== 32'h10) begin n_fail++; $display("FAIL alu_aluout: got %h exp 10", ALUOutW); end
      n_checks++; if (WriteRegW !== 5'd5) begin n_fail++; $display("FAIL alu_writereg: got %h exp 5", WriteRegW); end
      n_checks++; if (MemToRegW !== 1'b0) begin n_fail++; $display("FAIL alu_memtoreg: got %h exp 0", MemToRegW); end
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic test_store();
      @(negedge CLK);
      set_m(1'b0, 1'b0, 1'b1, 32'h100, 32'hCAFE, 5'd0);
      mem_bus.mem_req_ready = 1'b1;
      #1;
      n_checks++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL st_stall_idle: got %h exp 1", StallM); end
      n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL st_valid_idle: got %h exp 0", mem_bus.mem_req_valid); end
      @(negedge CLK); // REQ
      n_checks++; if (mem_bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid_req: got %h exp 1", mem_bus.mem_req_valid); end
      n_checks++; if (mem_bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL st_addr: got %h exp 100", mem_bus.mem_addr); end
      n_checks++; if (mem_bus.mem_wdata !== 32'hCAFE) begin n_fail++; $display("FAIL st_wdata: got %h exp cafe", mem_bus.mem_wdata); end
      n_checks++; if (mem_bus.mem_req_we !== 1'b1) begin n_fail++; $display("FAIL st_we: got %h exp 1", mem_bus.mem_req_we); end
      n_checks++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL st_stall_req: got %h exp 1", StallM); end
      n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL st_bubble: got %h exp 0", RegWriteW); end
      @(negedge CLK); // DONE
      mem_bus.mem_req_ready = 1'b0;
      n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL st_valid_done: got %h exp 0", mem_bus.mem_req_valid); end
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL st_stall_done: got %h exp 0", StallM); end
      n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL st_regwrite_done: got %h exp 0", RegWriteW); end
      n_checks++; if (MemErr !== 1'b0) begin n_fail++; $display("FAIL st_memerr: got %h exp 0", MemErr); end
      @(negedge CLK); // IDLE
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic test_load();
      @(negedge CLK);
      set_m(1'b1, 1'b1, 1'b0, 32'h200, 32'd0, 5'd7);
      mem_bus.mem_req_ready = 1'b0;
      #1;
      n_checks++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL ld_stall_idle: got %h exp 1", StallM); end
      @(negedge CLK); // REQ 1: stray response must be ignored
      n_checks++; if (mem_bus.mem_req_we !== 1'b0) begin n_fail++; $display("FAIL ld_we: got %h exp 0", mem_bus.mem_req_we); end
      n_checks++; if (mem_bus.mem_addr !== 32'h200) begin n_fail++; $display("FAIL ld_addr: got %h exp 200", mem_bus.mem_addr); end
      mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rdata = 32'h5555;
      @(negedge CLK); // REQ 2
      mem_bus.mem_rsp_valid = 1'b0;
      n_checks++; if (mem_bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL ld_valid_req2: got %h exp 1", mem_bus.mem_req_valid); end
      n_checks++; if (ReadDataW !== 32'd0) begin n_fail++; $display("FAIL ld_rsp_in_req: got %h exp 0", ReadDataW); end
      mem_bus.mem_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK); // WAIT 1..3
         mem_bus.mem_req_ready = 1'b0;
         n_checks++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL ld_stall_wait%0d: got %h exp 1", i, StallM); end
         n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ld_valid_wait%0d: got %h exp 0", i, mem_bus.mem_req_valid); end
      end
      mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rdata = 32'h1234;
      @(negedge CLK); // DONE
      mem_bus.mem_rsp_valid = 1'b0;
      n_checks++; if (ReadDataW !== 32'h1234) begin n_fail++; $display("FAIL ld_rdata: got %h exp 1234", ReadDataW); end
      n_checks++; if (RegWriteW !== 1'b1) begin n_fail++; $display("FAIL ld_regwrite: got %h exp 1", RegWriteW); end
      n_checks++; if (MemToRegW !== 1'b1) begin n_fail++; $display("FAIL ld_memtoreg: got %h exp 1", MemToRegW); end
      n_checks++; if (WriteRegW !== 5'd7) begin n_fail++; $display("FAIL ld_writereg: got %h exp 7", WriteRegW); end
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL ld_stall_done: got %h exp 0", StallM); end
      @(negedge CLK); // IDLE: bubble even though M still holds the load
      n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL ld_no_double_write: got %h exp 0", RegWriteW); end
      n_checks++; if (MemToRegW !== 1'b0) begin n_fail++; $display("FAIL ld_bubble_m2r: got %h exp 0", MemToRegW); end
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic test_timeout();
      @(negedge CLK);
      set_m(1'b1, 1'b1, 1'b0, 32'h300, 32'd0, 5'd9);
      mem_bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         n_checks++; if (mem_bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL to_valid_c%0d: got %h exp 1", i, mem_bus.mem_req_valid); end
      end
      @(negedge CLK); // DONE after abort
      n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL to_valid_drop: got %h exp 0", mem_bus.mem_req_valid); end
      n_checks++; if (MemErr !== 1'b1) begin n_fail++; $display("FAIL to_memerr: got %h exp 1", MemErr); end
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL to_stall: got %h exp 0", StallM); end
      n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL to_regwrite: got %h exp 0", RegWriteW); end
      n_checks++; if (ReadDataW !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_readdata: got %h exp deadbeef", ReadDataW); end
      @(negedge CLK); // IDLE
      n_checks++; if (MemErr !== 1'b0) begin n_fail++; $display("FAIL to_memerr_pulse: got %h exp 0", MemErr); end
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic test_timeout_tie();
      // Store accepted on the last allowed REQ cycle: completion wins.
      @(negedge CLK);
      set_m(1'b0, 1'b0, 1'b1, 32'h500, 32'h77, 5'd0);
      mem_bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         if (i == 15) mem_bus.mem_req_ready = 1'b1;
      end
      @(negedge CLK); // DONE
      mem_bus.mem_req_ready = 1'b0;
      n_checks++; if (MemErr !== 1'b0) begin n_fail++; $display("FAIL tie_memerr: got %h exp 0", MemErr); end
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL tie_stall: got %h exp 0", StallM); end
      @(negedge CLK);
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic test_reset_in_wait();
      @(negedge CLK);
      set_m(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd4);
      mem_bus.mem_req_ready = 1'b1;
      @(negedge CLK); // REQ, accepted at next edge
      @(negedge CLK); // WAIT
      mem_bus.mem_req_ready = 1'b0;
      n_checks++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL rw_stall_wait: got %h exp 1", StallM); end
      rst = 1'b1;
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      @(negedge CLK);
      rst = 1'b0;
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL rw_stall: got %h exp 0", StallM); end
      n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid: got %h exp 0", mem_bus.mem_req_valid); end
      n_checks++; if (ReadDataW !== 32'd0) begin n_fail++; $display("FAIL rw_readdata: got %h exp 0", ReadDataW); end
      n_checks++; if (ALUOutW !== 32'd0) begin n_fail++; $display("FAIL rw_aluout: got %h exp 0", ALUOutW); end
      n_checks++; if (mem_bus.mem_addr !== 32'd0) begin n_fail++; $display("FAIL rw_addr: got %h exp 0", mem_bus.mem_addr); end
      mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rdata = 32'h9999;
      @(negedge CLK);
      mem_bus.mem_rsp_valid = 1'b0;
      n_checks++; if (ReadDataW !== 32'd0) begin n_fail++; $display("FAIL rw_late_rsp: got %h exp 0", ReadDataW); end
      n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL rw_regwrite: got %h exp 0", RegWriteW); end
   endtask

   task automatic test_misaligned();
      @(negedge CLK);
      set_m(1'b1, 1'b1, 1'b0, 32'h102, 32'd0, 5'd3);
      #1;
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %h exp 0", StallM); end
      @(negedge CLK);
      n_checks++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %h exp 0", mem_bus.mem_req_valid); end
      n_checks++; if (MemErr !== 1'b1) begin n_fail++; $display("FAIL mis_memerr: got %h exp 1", MemErr); end
      n_checks++; if (ReadDataW !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mis_readdata: got %h exp deadbeef", ReadDataW); end
      n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL mis_regwrite: got %h exp 0", RegWriteW); end
      n_checks++; if (WriteRegW !== 5'd3) begin n_fail++; $display("FAIL mis_writereg: got %h exp 3", WriteRegW); end
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      @(negedge CLK);
      n_checks++; if (MemErr !== 1'b0) begin n_fail++; $display("FAIL mis_memerr_pulse: got %h exp 0", MemErr); end
   endtask

   task automatic test_back_to_back();
      @(negedge CLK);
      set_m(1'b1, 1'b0, 1'b0, 32'h11, 32'd0, 5'd1);
      @(negedge CLK);
      n_checks++; if (ALUOutW !== 32'h11) begin n_fail++; $display("FAIL b2b_alu1: got %h exp 11", ALUOutW); end
      set_m(1'b1, 1'b0, 1'b0, 32'h22, 32'd0, 5'd2);
      @(negedge CLK);
      n_checks++; if (ALUOutW !== 32'h22) begin n_fail++; $display("FAIL b2b_alu2: got %h exp 22", ALUOutW); end
      n_checks++; if (WriteRegW !== 5'd2) begin n_fail++; $display("FAIL b2b_wr2: got %h exp 2", WriteRegW); end
      // Both MemToRegM and MemWriteM set: handled as a store.
      set_m(1'b0, 1'b1, 1'b1, 32'h600, 32'hAB, 5'd0);
      mem_bus.mem_req_ready = 1'b1;
      @(negedge CLK); // REQ
      n_checks++; if (mem_bus.mem_req_we !== 1'b1) begin n_fail++; $display("FAIL b2b_both_we: got %h exp 1", mem_bus.mem_req_we); end
      @(negedge CLK); // DONE, not WAIT
      mem_bus.mem_req_ready = 1'b0;
      n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL b2b_both_done: got %h exp 0", StallM); end
      @(negedge CLK);
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
   endtask

   // Test sequence.
   initial begin
      test_reset();
      test_alu();
      test_store();
      test_load();
      test_timeout();
      test_timeout_tie();
      test_reset_in_wait();
      test_misaligned();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline interface: takes M-stage control and data, performs the data-memory access over a valid/ready request and valid response bus, and registers the MEM/WB outputs.
- Stalls the upstream pipeline while a load or store is outstanding.
- Inserts W-stage bubbles so the register file is never written twice.
- Sits between the EX/MEM register and the writeback mux / hazard unit.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ+WAIT before the access is aborted (valid range 2..255).
- ERR_DATA, 32'hDEAD_BEEF, value driven on ReadDataW for an aborted or misaligned load.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWriteM  in  1  M-stage register-write enable.
- MemToRegM  in  1  M-stage load indicator.
- MemWriteM  in  1  M-stage store indicator.
- ALUOutM  in  32  M-stage ALU result, also the memory byte address.
- WritedataM  in  32  M-stage store data.
- WriteRegM  in  5  M-stage destination register.
- StallM  out  1  freeze EX/MEM and earlier stages this cycle.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request when valid&ready.
- mem_req_we  out  1  1=store, 0=load.
- mem_addr  out  32  word address: {ALUOutM[31:2],2'b00} as latched.
- mem_wdata  out  32  store data as latched.
- mem_rsp_valid  in  1  load data valid (one-cycle pulse).
- mem_rdata  in  32  load data.
- RegWriteW  out  1  W-stage register-write enable.
- MemToRegW  out  1  W-stage load indicator.
- ALUOutW  out  32  W-stage ALU result.
- ReadDataW  out  32  W-stage load data.
- WriteRegW  out  5  W-stage destination register.
- MemErr  out  1  one-cycle pulse on misaligned or timed-out access.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; timeout counter clears.
  - All W outputs, latched address/data/we, and MemErr go to 0.
  - mem_req_valid=0 and StallM=0 from the following cycle.
  - Reset mid-access abandons the access; a late mem_rsp_valid in IDLE is ignored.
- memop = MemToRegM | MemWriteM. If both are set, treat as a store.
- IDLE, memop=0:
  - StallM=0.
  - W regs load M inputs on the edge: RegWriteM, MemToRegM, ALUOutM, WriteRegM; ReadDataW unchanged.
  - Latency is 1 cycle.
- IDLE, memop=1, ALUOutM[1:0]!=0 (misaligned):
  - StallM=0; no request issued.
  - Next cycle: MemErr=1; W regs load the op with RegWriteW=0; ReadDataW=ERR_DATA for a load.
- IDLE, memop=1, aligned:
  - StallM=1 (combinational).
  - Latch address, wdata and we; go to REQ; W regs load a bubble (RegWriteW=0, MemToRegW=0).
- REQ:
  - mem_req_valid=1 with address/data/we held stable; StallM=1.
  - On valid&ready: store goes to DONE; load goes to WAIT.
- WAIT:
  - StallM=1.
  - On mem_rsp_valid: capture mem_rdata into ReadDataW and go to DONE.
  - A rsp_valid arriving in REQ is ignored.
- Entering DONE:
  - W regs load the latched op: RegWriteW=RegWriteM, MemToRegW=MemToRegM, ALUOutW=ALUOutM, WriteRegW=WriteRegM.
  - M inputs are still held by the stall.
- DONE:
  - StallM=0; never evaluates memop.
  - On the next edge: go to IDLE and W regs load a bubble, so no double write.
- Timeout:
  - Counter increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completion: drop mem_req_valid, go to DONE with RegWriteW=0 and ReadDataW=ERR_DATA (load), and pulse MemErr for one cycle.
  - Completion and timeout in the same cycle: completion wins.
- Counter clears on entry to REQ.
- mem_req_valid is decoded only from the registered state (glitch-free).

Test Plan:
- ALU op: RegWriteM=1, ALUOutM=32'h10, WriteRegM=5, no memop → next cycle RegWriteW=1, ALUOutW=32'h10, WriteRegW=5; StallM stays 0.
- Store: ALUOutM=32'h100, WritedataM=32'hCAFE, ready=1 in REQ → StallM high 2 cycles; mem_addr=32'h100, mem_wdata=32'hCAFE, we=1 for 1 cycle; DONE after 2 cycles; RegWriteW never 1.
- Load with ready low 2 cycles, rsp 3 cycles after accept with rdata=32'h1234 → StallM high throughout; ReadDataW=32'h1234, MemToRegW=1, RegWriteW=1 for exactly one cycle.
- Misaligned load ALUOutM=32'h102 → no mem_req_valid; MemErr pulses; ReadDataW=32'hDEADBEEF; RegWriteW=0.
- Timeout: ready held 0 → after 16 cycles mem_req_valid drops, MemErr=1, StallM releases, RegWriteW=0.
- Reset asserted in WAIT → next cycle all outputs 0, IDLE; subsequent rsp_valid causes no W update.
